spi_tx_multi: RTL



---
 rtl/spi_tx_multi_if.sv | 7 +
 rtl/spi_tx_multi.sv | 76 +++++++
 2 files changed

// File: rtl/spi_tx_multi_if.sv
// spi_tx_multi_if: valid/ready word input plus SPI pin bundle for spi_tx_multi
interface spi_tx_multi_if #(parameter int DATA_W = 24);
  logic [DATA_W-1:0] bus_data;
  logic tx_valid, spi_ready, spi_cs, spi_clk, spi_data;
  modport master (output bus_data, tx_valid, input spi_ready, spi_cs, spi_clk, spi_data);
  modport slave (input bus_data, tx_valid, output spi_ready, spi_cs, spi_clk, spi_data);
endinterface

// File: rtl/spi_tx_multi.sv
// spi_tx_multi: parametrised SPI master transmitter; define SPI_TX_BURST_EN for back-to-back words under one CS
module spi_tx_multi #(
  parameter int DATA_W = 24,
  parameter int CLK_DIV = 12,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_GAP = 8
) (
  input logic clk,
  input logic RST,
  spi_tx_multi_if.slave bus
);
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  localparam int BW = $clog2(DATA_W + 1);
`ifdef SPI_TX_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_W-1:0] sreg, sreg_n, shifted;
  logic ph, ph_n, end_half, last_bit, last_cyc, hs, ev, cs_n, sck_n, sd_n;
  function automatic logic first_bit(input logic [DATA_W-1:0] x);
    return MSB_FIRST ? x[DATA_W-1] : x[0];
  endfunction
  assign end_half = cnt == CW'(CLK_DIV - 1);
  assign last_bit = bcnt == BW'(DATA_W - 1);
  assign last_cyc = state == SHIFT && end_half && ph && last_bit;
  assign bus.spi_ready = !RST && (state == IDLE || (BURST && last_cyc));
  assign hs = bus.spi_ready && bus.tx_valid;
  assign shifted = MSB_FIRST ? sreg << 1 : sreg >> 1;
  // ev marks the SCK edge that moves the next bit onto MOSI: leading edges for CPHA=1, trailing for CPHA=0
  assign ev = state == LEAD ? CPHA && end_half : state == SHIFT && end_half && !last_bit && ph == CPHA;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = hs ? LEAD : IDLE;
      LEAD: state_n = end_half ? SHIFT : LEAD;
      SHIFT: state_n = !last_cyc ? SHIFT : hs ? LEAD : TRAIL;
      TRAIL: state_n = !end_half ? TRAIL : CS_GAP == 0 ? IDLE : GAP;
      GAP: state_n = cnt == CW'(CS_GAP - 1) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
    cnt_n = (state_n != state || state == IDLE || (state != GAP && end_half)) ? '0 : cnt + 1'b1;
    ph_n = state_n != state ? 1'b0 : ph ^ (state == SHIFT && end_half);
    bcnt_n = state_n != state ? '0 : bcnt + BW'(state == SHIFT && end_half && ph);
    sreg_n = hs ? bus.bus_data : ev ? shifted : sreg;
    cs_n = !(state_n inside {LEAD, SHIFT, TRAIL});
    sck_n = CPOL ^ (state_n == SHIFT && !ph_n);
    sd_n = cs_n ? 1'b0 : hs ? !CPHA && first_bit(bus.bus_data) : ev ? first_bit(CPHA ? sreg : shifted) : bus.spi_data;
  end
  always_ff @(posedge clk)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      ph <= 1'b0;
      bcnt <= '0;
      sreg <= '0;
      bus.spi_cs <= 1'b1;
      bus.spi_clk <= CPOL;
      bus.spi_data <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ph <= ph_n;
      bcnt <= bcnt_n;
      sreg <= sreg_n;
      bus.spi_cs <= cs_n;
      bus.spi_clk <= sck_n;
      bus.spi_data <= sd_n;
    end
endmodule
